// File: rtl/debounce_toggle_gen_pkg.sv
// debounce_pkg: FSM state encoding and counter width helper for debounce_toggle_gen
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed to hold values 0..n without wrapping
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: multi-flop synchroniser for an asynchronous single-bit input, resets to 0
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw level through the chain; the last flop is the safe sample
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], d};

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_toggle_gen.sv
// debounce_toggle_gen: synchronise, debounce and convert a button press into a one-cycle toggle pulse; optional auto-repeat with AUTO_REPEAT_EN
module debounce_toggle_gen
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic clear_n,
  input  logic btn_in,
  output logic t_pulse,
  output logic btn_level,
  output logic bouncing
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = cnt_w(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;
`endif

  logic             w_btn_s;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;
  logic             r_bouncing;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (btn_in),
    .q       (w_btn_s)
  );

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // Debounce FSM with stability counter; outputs registered alongside the state
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pulse    <= 1'b0;
      r_level    <= 1'b0;
      r_bouncing <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rpt      <= '0;
`endif
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE:
          if (w_btn_s) begin
            r_state    <= PRESS_WAIT;
            r_cnt      <= CNT_ONE;
            r_bouncing <= 1'b1;
          end
        PRESS_WAIT:
          if (!w_btn_s) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bouncing <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= HELD;
            r_cnt      <= '0;
            r_pulse    <= 1'b1;
            r_level    <= 1'b1;
            r_bouncing <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rpt      <= '0;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        HELD:
          if (!w_btn_s) begin
            r_state    <= RELEASE_WAIT;
            r_cnt      <= CNT_ONE;
            r_bouncing <= 1'b1;
`ifdef AUTO_REPEAT_EN
            r_rpt      <= '0;
          end else if (r_rpt == RPT_LAST) begin
            r_rpt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_rpt <= r_rpt + 1'b1;
`endif
          end
        RELEASE_WAIT:
          if (w_btn_s) begin
            r_state    <= HELD;
            r_cnt      <= '0;
            r_bouncing <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rpt      <= '0;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_bouncing <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_level    <= 1'b0;
          r_bouncing <= 1'b0;
        end
      endcase
    end

  assign t_pulse   = r_pulse;
  assign btn_level = r_level;
  assign bouncing  = r_bouncing;

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// tb_debounce_toggle_gen: table-driven directed check of debounce_toggle_gen (SYNC=2, DEBOUNCE=4, REPEAT=8); honours AUTO_REPEAT_EN
module tb_debounce_toggle_gen;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    bit btn;
    bit clr;
    bit p;
    bit l;
    bit b;
  } vec_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic btn_in = 1'b0;
  logic t_pulse, btn_level, bouncing;

  int vectors = 0;
  int miscompares = 0;
  vec_t tv[$];

  debounce_toggle_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .btn_in    (btn_in),
    .t_pulse   (t_pulse),
    .btn_level (btn_level),
    .bouncing  (bouncing)
  );

  always #5 clk = ~clk;

  task automatic push(input bit btn, input bit clr, input bit p, input bit l, input bit b, input int n);
    vec_t v;
    v.btn = btn; v.clr = clr; v.p = p; v.l = l; v.b = b;
    for (int i = 0; i < n; i++) tv.push_back(v);
  endtask

  task automatic reset_pair();
    push(0, 0, 0, 0, 0, 1);
    push(0, 1, 0, 0, 0, 1);
  endtask

  // Press accepted at step 6 after the raw edge: steps 1-2 sync, 3-5 qualify, 6 pulse
  task automatic press_accept();
    push(1, 1, 0, 0, 0, 2);
    push(1, 1, 0, 0, 1, 3);
    push(1, 1, 1, 1, 0, 1);
  endtask

  // Clean release from HELD: two sync steps, three qualify steps, IDLE on step 6
  task automatic clean_release();
    push(0, 1, 0, 1, 0, 2);
    push(0, 1, 0, 1, 1, 3);
    push(0, 1, 0, 0, 0, 5);
  endtask

  initial begin
    int lat;
    bit found;
    // reset state
    push(0, 0, 0, 0, 0, 2);
    push(0, 1, 0, 0, 0, 2);
    // clean press held 20 clocks; with auto-repeat an extra pulse 8 after the first
    press_accept();
    push(1, 1, 0, 1, 0, 7);
    push(1, 1, AR, 1, 0, 1);
    push(1, 1, 0, 1, 0, 6);
    reset_pair();
    // bounce: 3 high, 1 low, then high; only the second burst qualifies
    push(1, 1, 0, 0, 0, 2);
    push(1, 1, 0, 0, 1, 1);
    push(0, 1, 0, 0, 1, 1);
    push(1, 1, 0, 0, 1, 1);
    push(1, 1, 0, 0, 0, 1);
    push(1, 1, 0, 0, 1, 3);
    push(1, 1, 1, 1, 0, 1);
    push(1, 1, 0, 1, 0, 4);
    reset_pair();
    // release bounce: level stays high, no pulse; then clean release
    press_accept();
    push(1, 1, 0, 1, 0, 1);
    push(0, 1, 0, 1, 0, 2);
    push(1, 1, 0, 1, 1, 2);
    push(1, 1, 0, 1, 0, 3);
    clean_release();
    // reset mid PRESS_WAIT at cnt=2, button kept held
    push(1, 1, 0, 0, 0, 2);
    push(1, 1, 0, 0, 1, 2);
    push(1, 0, 0, 0, 0, 1);
    push(1, 1, 0, 0, 0, 2);
    push(1, 1, 0, 0, 1, 3);
    push(1, 1, 1, 1, 0, 1);
    push(1, 1, 0, 1, 0, 1);
    reset_pair();
    // glitch train: 1-clock highs every 3 clocks never qualify
    for (int k = 1; k <= 50; k++) push(k % 3 == 1, 1, 0, 0, k % 3 == 0, 1);
    push(0, 1, 0, 0, 1, 1);
    push(0, 1, 0, 0, 0, 2);
    // long hold: repeat pulses at +8, +16, +24 only with auto-repeat; none after release
    press_accept();
    for (int j = 1; j <= 28; j++) push(1, 1, AR && (j % 8 == 0), 1, 0, 1);
    clean_release();

    foreach (tv[i]) begin
      @(negedge clk);
      btn_in = tv[i].btn;
      clear_n = tv[i].clr;
      @(posedge clk);
      #1;
      vectors++;
      if ({t_pulse, btn_level, bouncing} !== {tv[i].p, tv[i].l, tv[i].b}) begin
        miscompares++;
        $display("FAIL vec%0d: pulse/level/bouncing=%b%b%b required %b%b%b", i,
                 t_pulse, btn_level, bouncing, tv[i].p, tv[i].l, tv[i].b);
      end
    end

    // latency from clean raw edge, bounded wait
    @(negedge clk);
    btn_in = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (t_pulse) begin
        found = 1'b1;
        lat = c;
      end
    end
    vectors++;
    if (lat != 6) begin
      miscompares++;
      $display("FAIL latency: pulse after %0d clocks (0 = none in 20) required 6", lat);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (t_pulse !== 1'b0 || btn_level !== 1'b1) begin
      miscompares++;
      $display("FAIL single_width: pulse=%b level=%b required pulse=0 level=1", t_pulse, btn_level);
    end
    // asynchronous clear mid-cycle, no clock edge in between
    #2;
    clear_n = 1'b0;
    #1;
    vectors++;
    if ({t_pulse, btn_level, bouncing} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_clear: pulse/level/bouncing=%b%b%b required 000", t_pulse, btn_level, bouncing);
    end
    @(negedge clk);
    clear_n = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
